// File: rtl/bridge_buf_ctrl_if.sv
// Handshake bundle for the north and west word streams entering the bridge buffers.
interface bridge_buf_ctrl_if;
  logic in_valid_n;
  logic in_ready_n;
  logic in_valid_w;
  logic in_ready_w;

  modport master (output in_valid_n, output in_valid_w, input in_ready_n, input in_ready_w);
  modport slave  (input in_valid_n, input in_valid_w, output in_ready_n, output in_ready_w);
endinterface

// File: rtl/bridge_buf_ctrl.sv
// Buffer controller between the input streams and the systolic matmul core.
// Slices incoming north/west words into the buffer RAMs, tracks which west
// banks and north block-columns are loaded, and sequences tile reads.
module bridge_buf_ctrl #(
  parameter int TOTAL_MODULES = 4,
  parameter int INNER_BLOCKS  = 2,
  parameter int COL_Y         = 2,
  parameter int ROW_Y         = 2,
  parameter int NUM_W_BANKS   = 2,
  localparam int N_DEPTH  = INNER_BLOCKS * COL_Y * TOTAL_MODULES,
  localparam int W_DEPTH  = INNER_BLOCKS * TOTAL_MODULES,
  localparam int ADDR_N   = $clog2(N_DEPTH),
  localparam int ADDR_W   = $clog2(W_DEPTH),
  localparam int MAX_FLAG = ROW_Y * COL_Y,
  localparam int SLICE_W  = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1,
  localparam int BANK_W   = $clog2(NUM_W_BANKS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bridge_buf_ctrl_if.slave         bus,
  input  logic                     systolic_finish_wrap,
  input  logic                     acc_done_wrap,
  output logic                     n_wea,
  output logic [ADDR_N-1:0]        n_addra,
  output logic                     n_enb,
  output logic [ADDR_N-1:0]        n_addrb,
  output logic [NUM_W_BANKS-1:0]   w_wea,
  output logic [ADDR_W-1:0]        w_addra,
  output logic                     w_enb,
  output logic [ADDR_W-1:0]        w_addrb,
  output logic [BANK_W-1:0]        w_rd_bank,
  output logic [SLICE_W-1:0]       n_slicing_idx,
  output logic [SLICE_W-1:0]       w_slicing_idx,
  output logic                     enable_matmul,
  output logic                     internal_rst_n_ctrl,
  output logic                     internal_reset_acc_ctrl,
  output logic                     out_valid,
  output logic                     done
);

  localparam int COL_W  = (COL_Y > 1) ? $clog2(COL_Y) : 1;
  localparam int ROW_W  = $clog2(ROW_Y + 1);
  localparam int K_W    = (INNER_BLOCKS > 1) ? $clog2(INNER_BLOCKS) : 1;
  localparam int FLAG_W = $clog2(MAX_FLAG + 1);
  localparam int NRDY_W = $clog2(COL_Y + 1);

  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(TOTAL_MODULES - 1);
  localparam logic [ADDR_N-1:0]  N_LAST     = ADDR_N'(N_DEPTH - 1);
  localparam logic [ADDR_W-1:0]  W_LAST     = ADDR_W'(W_DEPTH - 1);
  localparam logic [BANK_W-1:0]  BANK_LAST  = BANK_W'(NUM_W_BANKS - 1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COL_Y - 1);
  localparam logic [K_W-1:0]     K_LAST     = K_W'(INNER_BLOCKS - 1);
  localparam logic [FLAG_W-1:0]  FLAG_MAX   = FLAG_W'(MAX_FLAG);
  localparam logic [NRDY_W-1:0]  NRDY_MAX   = NRDY_W'(COL_Y);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  logic                   r_active;
  logic                   r_n_burst;
  logic [SLICE_W-1:0]     r_n_slice;
  logic [ADDR_N-1:0]      r_n_addra;
  logic                   r_n_full;
  logic [NRDY_W-1:0]      r_n_ready;
  logic                   r_w_burst;
  logic [SLICE_W-1:0]     r_w_slice;
  logic [ADDR_W-1:0]      r_w_addra;
  logic [BANK_W-1:0]      r_wr_bank;
  logic [BANK_W-1:0]      r_rd_bank;
  logic [NUM_W_BANKS-1:0] r_bank_full;
  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  logic [K_W-1:0]         r_k;
  logic [FLAG_W-1:0]      r_flag;
  logic                   r_acc_d;
  logic                   r_out_valid;
  logic                   r_int_rst_n;
  logic                   r_int_rst_acc;

  logic                   w_done;
  logic                   w_ready_n;
  logic                   w_ready_w;
  logic                   w_n_hs;
  logic                   w_w_hs;
  logic                   w_n_we;
  logic                   w_w_we;
  logic                   w_n_blk_end;
  logic                   w_w_fill;
  logic                   w_readable;
  logic                   w_en;
  logic                   w_acc_rise;
  logic                   w_tile_evt;
  logic                   w_fin_evt;
  logic                   w_release;
  logic [FLAG_W-1:0]      w_flag_nxt;

  assign w_done      = (r_state == S_DONE);
  // Ready stays low until the first edge after reset release, so it rises one cycle later.
  assign w_ready_n   = r_active && !r_n_burst && !r_n_full && !w_done;
  assign w_ready_w   = r_active && !r_w_burst && !r_bank_full[r_wr_bank] && !w_done;
  assign w_n_hs      = bus.in_valid_n && w_ready_n;
  assign w_w_hs      = bus.in_valid_w && w_ready_w;
  assign w_n_we      = r_n_burst && !w_done;
  assign w_w_we      = r_w_burst && !w_done;
  // A north write closing a full block-column makes that column readable.
  assign w_n_blk_end = ((int'(r_n_addra) + 1) % W_DEPTH) == 0;
  assign w_w_fill    = w_w_we && (r_w_addra == W_LAST);
  assign w_readable  = r_bank_full[r_rd_bank] && (int'(r_n_ready) > int'(r_col));
  assign w_en        = w_readable && (r_state == S_RUN);
  assign w_acc_rise  = acc_done_wrap && !r_acc_d;
  assign w_tile_evt  = w_acc_rise && w_en;
  assign w_fin_evt   = systolic_finish_wrap && w_en;
  assign w_release   = w_tile_evt && (r_col == COL_LAST);

  // Tile counter advance, saturating at the total tile count.
  always_comb begin
    w_flag_nxt = r_flag;
    if (w_tile_evt && (r_flag != FLAG_MAX)) w_flag_nxt = r_flag + FLAG_W'(1);
  end

  // Top-level sequencing: idle until north data arrives, run until every tile is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_n_hs) r_state <= S_RUN;
        S_RUN:   if (w_flag_nxt == FLAG_MAX) r_state <= S_DONE;
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath control pulses and acc_done edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active      <= 1'b0;
      r_acc_d       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_int_rst_n   <= 1'b0;
      r_int_rst_acc <= 1'b0;
    end else begin
      r_active      <= 1'b1;
      r_acc_d       <= acc_done_wrap;
      r_out_valid   <= w_tile_evt;
      r_int_rst_n   <= !systolic_finish_wrap;
      r_int_rst_acc <= w_acc_rise;
    end
  end

  // North burst: each accepted word is written as TOTAL_MODULES slices to consecutive addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n_burst <= 1'b0;
      r_n_slice <= '0;
      r_n_addra <= '0;
      r_n_full  <= 1'b0;
      r_n_ready <= '0;
    end else if (w_done) begin
      r_n_burst <= 1'b0;
      r_n_slice <= '0;
    end else if (r_n_burst) begin
      if (r_n_addra == N_LAST) r_n_full <= 1'b1;
      else                     r_n_addra <= r_n_addra + ADDR_N'(1);
      if (w_n_blk_end && (r_n_ready != NRDY_MAX)) r_n_ready <= r_n_ready + NRDY_W'(1);
      if (r_n_slice == SLICE_LAST) begin
        r_n_burst <= 1'b0;
        r_n_slice <= '0;
      end else begin
        r_n_slice <= r_n_slice + SLICE_W'(1);
      end
    end else if (w_n_hs) begin
      r_n_burst <= 1'b1;
      r_n_slice <= '0;
    end
  end

  // West burst into the current write bank; a completed bank rotates to the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_burst <= 1'b0;
      r_w_slice <= '0;
      r_w_addra <= '0;
      r_wr_bank <= '0;
    end else if (w_done) begin
      r_w_burst <= 1'b0;
      r_w_slice <= '0;
    end else if (r_w_burst) begin
      if (w_w_fill) begin
        r_w_addra <= '0;
        r_wr_bank <= (r_wr_bank == BANK_LAST) ? '0 : r_wr_bank + BANK_W'(1);
      end else begin
        r_w_addra <= r_w_addra + ADDR_W'(1);
      end
      if (r_w_slice == SLICE_LAST) begin
        r_w_burst <= 1'b0;
        r_w_slice <= '0;
      end else begin
        r_w_slice <= r_w_slice + SLICE_W'(1);
      end
    end else if (w_w_hs) begin
      r_w_burst <= 1'b1;
      r_w_slice <= '0;
    end
  end

  // Bank occupancy: fill sets, row release clears; a fill wins when both hit one bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= '0;
    end else begin
      for (int b = 0; b < NUM_W_BANKS; b++) begin
        if (w_w_fill && (r_wr_bank == BANK_W'(b)))        r_bank_full[b] <= 1'b1;
        else if (w_release && (r_rd_bank == BANK_W'(b)))  r_bank_full[b] <= 1'b0;
      end
    end
  end

  // Tile read sequencing: block-product index, tile column/row and read bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_rd_bank <= '0;
      r_flag    <= '0;
    end else begin
      if (w_fin_evt) r_k <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
      if (w_tile_evt) begin
        r_flag <= w_flag_nxt;
        if (r_col == COL_LAST) begin
          r_col     <= '0;
          r_row     <= r_row + ROW_W'(1);
          r_rd_bank <= (r_rd_bank == BANK_LAST) ? '0 : r_rd_bank + BANK_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign bus.in_ready_n          = w_ready_n;
  assign bus.in_ready_w          = w_ready_w;
  assign n_wea                   = w_n_we;
  assign n_addra                 = r_n_addra;
  assign n_enb                   = w_en;
  assign n_addrb                 = ADDR_N'((int'(r_col) * INNER_BLOCKS + int'(r_k)) * TOTAL_MODULES);
  assign w_wea                   = w_w_we ? (NUM_W_BANKS'(1) << r_wr_bank) : '0;
  assign w_addra                 = r_w_addra;
  assign w_enb                   = w_en;
  assign w_addrb                 = ADDR_W'(int'(r_k) * TOTAL_MODULES);
  assign w_rd_bank               = r_rd_bank;
  assign n_slicing_idx           = r_n_slice;
  assign w_slicing_idx           = r_w_slice;
  assign enable_matmul           = w_en;
  assign internal_rst_n_ctrl     = r_int_rst_n;
  assign internal_reset_acc_ctrl = r_int_rst_acc;
  assign out_valid               = r_out_valid;
  assign done                    = w_done;

endmodule

// File: tb/tb_bridge_buf_ctrl.sv
// Bench for bridge_buf_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the buffers.
module tb_bridge_buf_ctrl;
  localparam int TM = 4, IB = 2, CY = 2, RY = 2, NB = 2;
  localparam int N_DEPTH = IB * CY * TM;
  localparam int W_DEPTH = IB * TM;
  localparam int MAXF    = RY * CY;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sfw = 1'b0;
  logic adw = 1'b0;

  logic       n_wea, n_enb, w_enb, enable_matmul;
  logic [3:0] n_addra, n_addrb;
  logic [1:0] w_wea;
  logic [2:0] w_addra, w_addrb;
  logic [0:0] w_rd_bank;
  logic [1:0] n_slicing_idx, w_slicing_idx;
  logic       internal_rst_n_ctrl, internal_reset_acc_ctrl, out_valid, done;

  bridge_buf_ctrl_if bif();

  bridge_buf_ctrl #(.TOTAL_MODULES(TM), .INNER_BLOCKS(IB), .COL_Y(CY), .ROW_Y(RY), .NUM_W_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif),
    .systolic_finish_wrap(sfw), .acc_done_wrap(adw),
    .n_wea(n_wea), .n_addra(n_addra), .n_enb(n_enb), .n_addrb(n_addrb),
    .w_wea(w_wea), .w_addra(w_addra), .w_enb(w_enb), .w_addrb(w_addrb),
    .w_rd_bank(w_rd_bank), .n_slicing_idx(n_slicing_idx), .w_slicing_idx(w_slicing_idx),
    .enable_matmul(enable_matmul), .internal_rst_n_ctrl(internal_rst_n_ctrl),
    .internal_reset_acc_ctrl(internal_reset_acc_ctrl), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending slice writes as queues, loads as word counts, tiles as a single index.
  bit m_active, m_run, m_done;
  int m_nq[$];
  int m_wq[$];
  int m_n_written, m_w_addr, m_wr_bank, m_flag, m_k;
  bit m_bank_full[NB];
  bit m_acc_prev, m_ov, m_rstn, m_racc;

  function automatic int m_col();  return m_flag % CY; endfunction
  function automatic int m_row();  return m_flag / CY; endfunction
  function automatic int m_nrdy(); return (m_n_written / (IB * TM) > CY) ? CY : m_n_written / (IB * TM); endfunction
  function automatic bit m_en();
    return m_run && !m_done && m_bank_full[m_row() % NB] && (m_nrdy() > m_col());
  endfunction
  function automatic bit m_rdy_n(); return m_active && !m_done && m_nq.size() == 0 && m_n_written < N_DEPTH; endfunction
  function automatic bit m_rdy_w(); return m_active && !m_done && m_wq.size() == 0 && !m_bank_full[m_wr_bank]; endfunction

  function automatic void model_reset();
    m_active = 0; m_run = 0; m_done = 0;
    m_nq.delete(); m_wq.delete();
    m_n_written = 0; m_w_addr = 0; m_wr_bank = 0; m_flag = 0; m_k = 0;
    foreach (m_bank_full[b]) m_bank_full[b] = 0;
    m_acc_prev = 0; m_ov = 0; m_rstn = 0; m_racc = 0;
  endfunction

  function automatic void model_step(input bit vn, input bit vw, input bit sf, input bit ad);
    bit en, rn, rw, rise, evt, do_fill;
    int col, row, fill_bank;
    en = m_en(); rn = m_rdy_n(); rw = m_rdy_w();
    col = m_col(); row = m_row();
    rise = ad && !m_acc_prev;
    evt = rise && en;
    do_fill = 0; fill_bank = 0;
    m_acc_prev = ad; m_rstn = !sf; m_racc = rise; m_ov = evt;
    if (en && sf) m_k = (m_k + 1) % IB;
    if (m_done) begin
      m_nq.delete(); m_wq.delete();
    end else begin
      if (m_nq.size() > 0) begin void'(m_nq.pop_front()); m_n_written++; end
      if (m_wq.size() > 0) begin
        void'(m_wq.pop_front());
        if (m_w_addr == W_DEPTH - 1) begin
          do_fill = 1; fill_bank = m_wr_bank; m_w_addr = 0; m_wr_bank = (m_wr_bank + 1) % NB;
        end else m_w_addr++;
      end
    end
    if (vn && rn) begin for (int s = 0; s < TM; s++) m_nq.push_back(s); m_run = 1; end
    if (vw && rw) for (int s = 0; s < TM; s++) m_wq.push_back(s);
    if (evt) begin
      if (col == CY - 1) m_bank_full[row % NB] = 0;
      if (m_flag < MAXF) m_flag++;
      if (m_flag == MAXF) m_done = 1;
    end
    if (do_fill) m_bank_full[fill_bank] = 1;
    m_active = 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    int col;
    col = m_col();
    chk("n_wea", n_wea, !m_done && m_nq.size() > 0);
    chk("n_addra", n_addra, (m_n_written < N_DEPTH) ? m_n_written : N_DEPTH - 1);
    chk("n_slicing_idx", n_slicing_idx, (m_nq.size() > 0) ? m_nq[0] : 0);
    chk("in_ready_n", bif.in_ready_n, m_rdy_n());
    chk("w_wea", w_wea, (!m_done && m_wq.size() > 0) ? (1 << m_wr_bank) : 0);
    chk("w_addra", w_addra, m_w_addr);
    chk("w_slicing_idx", w_slicing_idx, (m_wq.size() > 0) ? m_wq[0] : 0);
    chk("in_ready_w", bif.in_ready_w, m_rdy_w());
    chk("enable_matmul", enable_matmul, m_en());
    chk("n_enb", n_enb, m_en());
    chk("w_enb", w_enb, m_en());
    chk("w_addrb", w_addrb, m_k * TM);
    chk("n_addrb", n_addrb, (col * IB + m_k) * TM);
    chk("w_rd_bank", w_rd_bank, m_row() % NB);
    chk("out_valid", out_valid, m_ov);
    chk("done", done, m_done);
    chk("internal_rst_n_ctrl", internal_rst_n_ctrl, m_rstn);
    chk("internal_reset_acc_ctrl", internal_reset_acc_ctrl, m_racc);
  endtask

  task automatic drive(input bit vn, input bit vw, input bit sf, input bit ad);
    bif.in_valid_n = vn; bif.in_valid_w = vw; sfw = sf; adw = ad;
  endtask

  task automatic cycle(input bit vn, input bit vw, input bit sf, input bit ad);
    @(negedge clk);
    check_all();
    drive(vn, vw, sf, ad);
    model_step(vn, vw, sf, ad);
  endtask

  task automatic reset_assert();
    #3;
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #1;
    check_all();
  endtask

  task automatic reset_release();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    model_step(0, 0, 0, 0);
  endtask

  initial begin
    int ov_cnt;
    int cyc;
    bit ad_lvl;
    drive(0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    check_all();
    chk("lit_reset_ready_n", bif.in_ready_n, 0);
    chk("lit_reset_rstn_ctrl", internal_rst_n_ctrl, 0);
    reset_release();
    cycle(0, 0, 0, 0);
    chk("lit_post_reset_ready_n", bif.in_ready_n, 1);
    chk("lit_post_reset_ready_w", bif.in_ready_w, 1);
    chk("lit_post_reset_rstn_ctrl", internal_rst_n_ctrl, 1);

    // One north word: four slice writes at addresses 0..3.
    cycle(1, 0, 0, 0);
    for (int i = 0; i < TM; i++) begin
      cycle(0, 0, 0, 0);
      chk("lit_nburst_wea", n_wea, 1);
      chk("lit_nburst_addr", n_addra, i);
      chk("lit_nburst_slice", n_slicing_idx, i);
      chk("lit_nburst_ready", bif.in_ready_n, 0);
    end
    cycle(0, 0, 0, 0);
    chk("lit_nafter_wea", n_wea, 0);
    chk("lit_nafter_addr", n_addra, 4);
    chk("lit_nafter_en", enable_matmul, 0);

    // Four west words fill both banks.
    for (int w = 0; w < 4; w++) begin
      cycle(0, 1, 0, 0);
      repeat (TM) cycle(0, 0, 0, 0);
    end
    cycle(0, 0, 0, 0);
    chk("lit_banks_full_ready_w", bif.in_ready_w, 0);

    // Second north word completes block-column 0.
    cycle(1, 0, 0, 0);
    repeat (TM) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("lit_tile0_en", enable_matmul, 1);
    chk("lit_tile0_naddrb", n_addrb, 0);
    chk("lit_tile0_waddrb", w_addrb, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("lit_k1_naddrb", n_addrb, 4);
    chk("lit_k1_waddrb", w_addrb, 4);
    chk("lit_k1_rstn_ctrl", internal_rst_n_ctrl, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("lit_k0_naddrb", n_addrb, 0);

    // acc_done held high for five cycles gives a single tile completion.
    ov_cnt = 0;
    repeat (5) begin cycle(0, 0, 0, 1); ov_cnt += int'(out_valid); end
    repeat (2) begin cycle(0, 0, 0, 0); ov_cnt += int'(out_valid); end
    chk("lit_one_out_valid", ov_cnt, 1);
    chk("lit_col1_not_ready", enable_matmul, 0);
    chk("lit_col1_naddrb", n_addrb, 8);

    // Randomized traffic until every tile is produced.
    cyc = 0; ad_lvl = 0;
    while (done !== 1'b1 && cyc < 4000) begin
      if ($urandom_range(0, 2) == 0) ad_lvl = !ad_lvl;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ad_lvl);
      cyc++;
    end
    chk("reach_done", done, 1);
    cycle(0, 0, 0, 0);
    chk("lit_done_ready_n", bif.in_ready_n, 0);
    chk("lit_done_ready_w", bif.in_ready_w, 0);
    chk("lit_done_en", enable_matmul, 0);
    ov_cnt = 0;
    for (int i = 0; i < 6; i++) begin cycle(0, 0, 1, i[0]); ov_cnt += int'(out_valid); end
    chk("lit_done_no_out_valid", ov_cnt, 0);

    // Reset from DONE, then abandon a west burst at slice 2.
    reset_assert();
    reset_release();
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    chk("lit_mid_slice", w_slicing_idx, 2);
    chk("lit_mid_addr", w_addra, 2);
    reset_assert();
    chk("lit_async_wea", w_wea, 0);
    chk("lit_async_waddra", w_addra, 0);
    chk("lit_async_wslice", w_slicing_idx, 0);
    chk("lit_async_ready_w", bif.in_ready_w, 0);
    chk("lit_async_rstn_ctrl", internal_rst_n_ctrl, 0);
    reset_release();
    cycle(0, 0, 0, 0);
    chk("lit_rel_waddra", w_addra, 0);
    chk("lit_rel_ready_w", bif.in_ready_w, 1);
    cycle(0, 1, 0, 0);
    repeat (TM) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("lit_partial_waddra", w_addra, 4);
    chk("lit_partial_ready_w", bif.in_ready_w, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bridge_buf_ctrl.md
BRIDGE_BUF_CTRL -- requirements
Module: bridge_buf_ctrl

Interface
REQ-001 Parameter TOTAL_MODULES, default 4: number of slices per input word, written to consecutive addresses.
REQ-002 Parameter INNER_BLOCKS, default 2: INNER_DIMENSION/BLOCK_SIZE, the block products accumulated per output tile.
REQ-003 Parameter COL_Y, default 2: output tile columns, one per north block-column.
REQ-004 Parameter ROW_Y, default 2: output tile rows, one per west row-block.
REQ-005 Parameter NUM_W_BANKS, default 2 (minimum 2): number of west banks, each INNER_BLOCKS*TOTAL_MODULES words deep.
REQ-006 Derived: N_DEPTH = INNER_BLOCKS*COL_Y*TOTAL_MODULES; W_DEPTH = INNER_BLOCKS*TOTAL_MODULES; ADDR_N = clog2(N_DEPTH); ADDR_W = clog2(W_DEPTH); MAX_FLAG = ROW_Y*COL_Y.
REQ-007 Ports, one per line:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid_n / in_ready_n  in / out  1 / 1  north word handshake.
- in_valid_w / in_ready_w  in / out  1 / 1  west word handshake.
- systolic_finish_wrap  in  1  one block product has completed.
- acc_done_wrap  in  1  tile accumulation is done; the block acts on the rising edge only.
- n_wea, n_addra  out  1, ADDR_N  north write port.
- n_enb, n_addrb  out  1, ADDR_N  north read port.
- w_wea  out  NUM_W_BANKS  one-hot west bank write enable.
- w_addra  out  ADDR_W  west write address.
- w_enb, w_addrb  out  1, ADDR_W  west read port.
- w_rd_bank  out  clog2(NUM_W_BANKS)  read-bank select.
- n_slicing_idx, w_slicing_idx  out  clog2(TOTAL_MODULES)  active slice.
- enable_matmul, internal_rst_n_ctrl, internal_reset_acc_ctrl  out  1  datapath control.
- out_valid, done  out  1  tile-complete pulse; all-tiles-complete level.

Function
REQ-008 FSM states and transitions:
- S_IDLE -> S_RUN when the first in_valid_n&in_ready_n handshake occurs.
- S_RUN -> S_DONE when flag==MAX_FLAG.
- S_DONE holds until reset.
REQ-009 North write burst:
- Each accepted north word gives TOTAL_MODULES consecutive write cycles, with n_wea=1 and n_slicing_idx running 0..TOTAL_MODULES-1.
- in_ready_n=0 during the burst, and permanently once n_addra has written N_DEPTH-1.
REQ-010 n_addra starts at 0, increments by 1 per write cycle, and never wraps.
REQ-011 n_ready increments, saturating at COL_Y, each time a write to address INNER_BLOCKS*TOTAL_MODULES*k-1 completes (k>=1).
REQ-012 West write burst: same slice burst as north, to bank wr_bank (w_wea one-hot).
- in_ready_w = !bank_full[wr_bank] && !burst_active && state!=S_DONE.
REQ-013 West bank fill: after writing address W_DEPTH-1, set bank_full[wr_bank], reset w_addra to 0, and advance wr_bank modulo NUM_W_BANKS.
REQ-014 Tile (row,col) is readable when bank_full[w_rd_bank] && n_ready>col; enable_matmul = readable && state==S_RUN.
REQ-015 Read addresses, per tile; k counts block products 0..INNER_BLOCKS-1, updated on systolic_finish_wrap and wrapping to 0:
- w_addrb = k*TOTAL_MODULES.
- n_addrb = (col*INNER_BLOCKS+k)*TOTAL_MODULES.
- w_enb and n_enb equal enable_matmul.
REQ-016 On an acc_done_wrap rising edge:
- out_valid pulses for exactly 1 cycle, and flag increments, saturating at MAX_FLAG.
- col increments; at COL_Y-1, col resets to 0, bank_full[w_rd_bank] clears, w_rd_bank advances modulo NUM_W_BANKS, and row increments.
REQ-017 Datapath control:
- internal_rst_n_ctrl = 0 for the cycle after systolic_finish_wrap, otherwise 1.
- internal_reset_acc_ctrl = 1 for the cycle after an acc_done_wrap rising edge, otherwise 0.
REQ-018 Simultaneous events: a bank release and a bank fill in the same cycle both take effect, with the clear and set applied to their respective banks. If they target the same bank, the set wins.
REQ-019 done = (state==S_DONE). In S_DONE, all enables are 0 and both ready outputs are 0.
REQ-020 Tile reads ignore systolic_finish_wrap and acc_done_wrap while enable_matmul=0.

Reset
REQ-021 rst_n low asynchronously forces:
- state to S_IDLE.
- All addresses, counters, slicing indices, bank_full, wr_bank, w_rd_bank, flag and n_ready to 0.
- Enables, write enables, out_valid and done to 0.
- Both ready outputs to 0.
- internal_rst_n_ctrl and internal_reset_acc_ctrl to 0.
REQ-022 Reset deassertion is taken synchronously on the next clk edge. One cycle after deassertion: in_ready_n=1, in_ready_w=1, internal_rst_n_ctrl=1.
REQ-023 A reset asserted mid-burst or mid-tile abandons all progress. No partial bank is marked full.

Verification
REQ-024 Defaults; send 1 north word -> n_wea=1 for 4 cycles at n_addra 0,1,2,3; n_slicing_idx runs 0..3; in_ready_n=0 during the burst; n_ready=0.
REQ-025 Load 2 west words (one full bank) and 2 north words -> bank_full[0]=1, wr_bank=1, n_ready=1, enable_matmul=1; two systolic_finish_wrap pulses -> n_addrb 0 then 4.
REQ-026 Fill both west banks with bank 0 unread -> in_ready_w=0; an acc_done_wrap edge at col=1 -> bank 0 released, w_rd_bank=1, in_ready_w=1 next cycle.
REQ-027 Hold acc_done_wrap high for 5 cycles -> exactly one out_valid pulse and flag +1.
REQ-028 Complete 4 tiles -> done=1, in_ready_n=0, in_ready_w=0, enable_matmul=0; further acc_done_wrap edges produce no out_valid.
REQ-029 Assert rst_n low mid west burst at slice 2 -> all outputs return to reset values immediately (asynchronously); after release, w_addra=0 and bank_full=0.
